// File: rtl/xpb_pkg.sv
// Shared constants and types for the XPB table generator.
//   XPB_WIDTH   : bit width of B, M and each table entry
//   XPB_ENTRIES : entries per table (power of 2)
//   XPB_LIMB    : adder limb width
//   XPB_AW      : entry index width
//   XPB_NLIMB   : limbs per WIDTH-bit word
package xpb_pkg;

  localparam int XPB_WIDTH   = 1024;
  localparam int XPB_ENTRIES = 32;
  localparam int XPB_LIMB    = 64;
  localparam int XPB_AW      = $clog2(XPB_ENTRIES);
  localparam int XPB_NLIMB   = XPB_WIDTH / XPB_LIMB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } xpb_gen_state_t;

endpackage

// File: rtl/xpb_limb_addsub.sv
// One limb of the add-then-conditionally-subtract datapath (combinational).
//   a, b   : accumulator limb and base limb
//   m      : modulus limb
//   cin    : carry in from the previous (lower) limb of a + b
//   bin    : borrow in from the previous limb of (a + b) - m
//   sum    : limb of a + b
//   diff   : limb of (a + b) - m
//   cout   : carry out of this limb's addition
//   bout   : borrow out of this limb's subtraction
module xpb_limb_addsub #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic [LIMB-1:0] m,
  input  logic            cin,
  input  logic            bin,
  output logic [LIMB-1:0] sum,
  output logic [LIMB-1:0] diff,
  output logic            cout,
  output logic            bout
);

  logic [LIMB:0] s_ext;
  logic [LIMB:0] d_ext;

  assign s_ext = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};
  // Extended subtraction: a negative result leaves the top bit set, which is
  // exactly the borrow into the next limb.
  assign d_ext = {1'b0, s_ext[LIMB-1:0]} - {1'b0, m} - {{LIMB{1'b0}}, bin};

  assign sum  = s_ext[LIMB-1:0];
  assign cout = s_ext[LIMB];
  assign diff = d_ext[LIMB-1:0];
  assign bout = d_ext[LIMB];

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime generator for XPB reduction tables: entry[k] = k*B mod M, k = 0..ENTRIES-1,
// written out through a simple RAM write port. One start builds one table.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE
//   base_in    : B (< M), latched on accepted start
//   mod_in     : M (> 1), latched on accepted start
//   busy       : high while a build is in progress (including the DONE cycle)
//   done       : single-cycle pulse after the last write
//   wr_en      : table write strobe
//   wr_addr    : entry index k
//   wr_data    : k*B mod M
// The running value acc is advanced by acc += B (mod M) one limb per cycle,
// LSB limb first, so only a LIMB-wide adder/subtractor is needed.
module xpb_table_gen import xpb_pkg::*; #(
  parameter int WIDTH   = XPB_WIDTH,
  parameter int ENTRIES = XPB_ENTRIES,
  parameter int LIMB    = XPB_LIMB
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           base_in,
  input  logic [WIDTH-1:0]           mod_in,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_en,
  output logic [$clog2(ENTRIES)-1:0] wr_addr,
  output logic [WIDTH-1:0]           wr_data
);

  localparam int AW    = $clog2(ENTRIES);
  localparam int NLIMB = WIDTH / LIMB;
  localparam int LW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [AW-1:0] K_LAST = AW'(ENTRIES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(NLIMB - 1);

  xpb_gen_state_t state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [LW-1:0]    limb_q, limb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             c_q, c_d;
  logic             bw_q, bw_d;

  logic [LIMB-1:0]  l_sum, l_diff;
  logic             l_cout, l_bout;
  logic [WIDTH-1:0] sum_full, diff_full;
  logic [WIDTH-1:0] acc_rot, b_rot, m_rot;

  // Operands are consumed from the low limb; acc, B and M rotate right so they
  // are back in place after NLIMB cycles. Result limbs enter sum/diff at the top,
  // so after NLIMB cycles the full words are aligned.
  generate
    if (NLIMB > 1) begin : g_multi
      assign sum_full  = {l_sum,  sum_q[WIDTH-1:LIMB]};
      assign diff_full = {l_diff, diff_q[WIDTH-1:LIMB]};
      assign acc_rot   = {acc_q[LIMB-1:0], acc_q[WIDTH-1:LIMB]};
      assign b_rot     = {b_q[LIMB-1:0],   b_q[WIDTH-1:LIMB]};
      assign m_rot     = {m_q[LIMB-1:0],   m_q[WIDTH-1:LIMB]};
    end else begin : g_single
      assign sum_full  = l_sum;
      assign diff_full = l_diff;
      assign acc_rot   = acc_q;
      assign b_rot     = b_q;
      assign m_rot     = m_q;
    end
  endgenerate

  xpb_limb_addsub #(.LIMB(LIMB)) u_limb (
    .a    (acc_q[LIMB-1:0]),
    .b    (b_q[LIMB-1:0]),
    .m    (m_q[LIMB-1:0]),
    .cin  (c_q),
    .bin  (bw_q),
    .sum  (l_sum),
    .diff (l_diff),
    .cout (l_cout),
    .bout (l_bout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    limb_d  = limb_q;
    acc_d   = acc_q;
    b_d     = b_q;
    m_d     = m_q;
    sum_d   = sum_q;
    diff_d  = diff_q;
    c_d     = c_q;
    bw_d    = bw_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = base_in;
          m_d     = mod_in;
          acc_d   = '0;
          k_d     = '0;
          limb_d  = '0;
          c_d     = 1'b0;
          bw_d    = 1'b0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + AW'(1);
          limb_d  = '0;
          c_d     = 1'b0;
          bw_d    = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        c_d    = l_cout;
        bw_d   = l_bout;
        sum_d  = sum_full;
        diff_d = diff_full;
        acc_d  = acc_rot;
        b_d    = b_rot;
        m_d    = m_rot;
        limb_d = limb_q + LW'(1);
        if (limb_q == L_LAST) begin
          // acc + B >= M exactly when the add carried out of WIDTH bits or the
          // subtraction of M did not borrow.
          acc_d   = (l_cout | ~l_bout) ? diff_full : sum_full;
          limb_d  = '0;
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      limb_q  <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      m_q     <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      c_q     <= 1'b0;
      bw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      limb_q  <= limb_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      m_q     <= m_d;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      c_q     <= c_d;
      bw_q    <= bw_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign wr_en   = (state_q == WRITE);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign wr_addr = k_q;
  assign wr_data = acc_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: a 16-bit/4-bit-limb instance for directed and
// random short builds, and a default 1024/32/64 instance for random wide builds.
// Expected entries come from direct k*B mod M arithmetic.
module tb_xpb_table_gen;

  localparam int E   = 32;
  localparam int SW  = 16;
  localparam int SL  = 4;
  localparam int SN  = SW / SL;
  localparam int LWD = 1024;
  localparam int LN  = 1024 / 64;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic          s_start;
  logic [SW-1:0] s_base, s_mod;
  logic          s_busy, s_done, s_wr_en;
  logic [4:0]    s_wr_addr;
  logic [SW-1:0] s_wr_data;

  // wide instance
  logic           l_start;
  logic [LWD-1:0] l_base, l_mod;
  logic           l_busy, l_done, l_wr_en;
  logic [4:0]     l_wr_addr;
  logic [LWD-1:0] l_wr_data;

  xpb_table_gen #(.WIDTH(SW), .ENTRIES(E), .LIMB(SL)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .base_in(s_base), .mod_in(s_mod),
    .busy(s_busy), .done(s_done), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  xpb_table_gen dut_l (
    .clk(clk), .rst_n(rst_n), .start(l_start), .base_in(l_base), .mod_in(l_mod),
    .busy(l_busy), .done(l_done), .wr_en(l_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got(lo128)=%0h exp(lo128)=%0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  // write monitors
  int             s_st, l_st;
  int             s_addr[$], s_cyc[$];
  logic [SW-1:0]  s_data[$];
  int             s_done_n = 0, s_done_cyc = 0;
  int             l_addr[$], l_cyc[$];
  logic [LWD-1:0] l_data[$];
  int             l_done_n = 0, l_done_cyc = 0;

  always @(negedge clk) begin
    if (s_wr_en) begin
      s_addr.push_back(int'(s_wr_addr));
      s_data.push_back(s_wr_data);
      s_cyc.push_back(cyc - s_st);
    end
    if (s_done) begin
      s_done_n   <= s_done_n + 1;
      s_done_cyc <= cyc - s_st;
    end
    if (l_wr_en) begin
      l_addr.push_back(int'(l_wr_addr));
      l_data.push_back(l_wr_data);
      l_cyc.push_back(cyc - l_st);
    end
    if (l_done) begin
      l_done_n   <= l_done_n + 1;
      l_done_cyc <= cyc - l_st;
    end
  end

  function automatic logic [SW-1:0] s_ref(input int k, input logic [SW-1:0] b, input logic [SW-1:0] m);
    logic [31:0] p;
    p = 32'(k) * 32'(b);
    return SW'(p % 32'(m));
  endfunction

  function automatic logic [LWD-1:0] l_ref(input int k, input logic [LWD-1:0] b, input logic [LWD-1:0] m);
    logic [1055:0] p;
    p = 1056'(k) * 1056'(b);
    return LWD'(p % 1056'(m));
  endfunction

  int s_w0;  // queue index of the first write of the most recent small build

  // mode 0: single pulse, 1: start held high, 2: start re-pulsed randomly while busy
  task automatic run_small(input string nm, input logic [SW-1:0] b, input logic [SW-1:0] m, input int mode);
    int  w0, d0, busy_lo, n;
    bit  got_done;
    w0 = s_addr.size();
    d0 = s_done_n;
    s_w0 = w0;
    @(negedge clk);
    s_base  = b;
    s_mod   = m;
    s_start = 1'b1;
    s_st    = cyc;
    busy_lo = 0;
    got_done = 0;
    for (int t = 0; t < 400 && !got_done; t++) begin
      @(negedge clk);
      if (mode == 0) s_start = 1'b0;
      else if (mode == 2) s_start = 1'($urandom_range(0, 1));
      if (!s_busy) busy_lo++;
      if (s_done) got_done = 1;
    end
    if (!got_done) chk({nm, "_done_timeout"}, 0, 1);
    // start is still high in the DONE cycle for modes 1/2; it must be ignored
    @(negedge clk);
    s_start = 1'b0;
    repeat (12) @(negedge clk);
    chk({nm, "_busy_during"}, busy_lo, 0);
    chk({nm, "_busy_after"}, s_busy, 0);
    chk({nm, "_n_done"}, s_done_n - d0, 1);
    chk({nm, "_done_cyc"}, s_done_cyc, E + (E - 1) * SN + 1);
    n = s_addr.size() - w0;
    chk({nm, "_n_wr"}, n, E);
    if (n > E) n = E;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), s_addr[w0+i], i);
      chk($sformatf("%s_data%0d", nm, i), s_data[w0+i], s_ref(i, b, m));
      chk($sformatf("%s_wcyc%0d", nm, i), s_cyc[w0+i], 1 + i * (SN + 1));
    end
  endtask

  task automatic run_large(input string nm, input logic [LWD-1:0] b, input logic [LWD-1:0] m);
    int w0, d0, n;
    bit got_done;
    w0 = l_addr.size();
    d0 = l_done_n;
    @(negedge clk);
    l_base  = b;
    l_mod   = m;
    l_start = 1'b1;
    l_st    = cyc;
    @(negedge clk);
    l_start = 1'b0;
    got_done = l_done;
    for (int t = 0; t < 700 && !got_done; t++) begin
      @(negedge clk);
      if (l_done) got_done = 1;
    end
    if (!got_done) chk({nm, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    chk({nm, "_n_done"}, l_done_n - d0, 1);
    chk({nm, "_done_cyc"}, l_done_cyc, E + (E - 1) * LN + 1);
    n = l_addr.size() - w0;
    chk({nm, "_n_wr"}, n, E);
    if (n > E) n = E;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), l_addr[w0+i], i);
      chk($sformatf("%s_data%0d", nm, i), l_data[w0+i], l_ref(i, b, m));
      chk($sformatf("%s_wcyc%0d", nm, i), l_cyc[w0+i], 1 + i * (LN + 1));
    end
  endtask

  initial begin
    logic [SW-1:0]  sb, sm;
    logic [LWD-1:0] lb, lm;
    int w0;
    rst_n   = 1'b0;
    s_start = 1'b0; s_base = '0; s_mod = '0;
    l_start = 1'b0; l_base = '0; l_mod = '0;
    s_st = 0; l_st = 0; s_w0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_wr_en", s_wr_en, 0);
    chk("rst_s_busy", s_busy, 0);
    chk("rst_s_done", s_done, 0);
    chk("rst_s_addr", s_wr_addr, 0);
    chk("rst_s_data", s_wr_data, 0);
    chk("rst_l_wr_en", l_wr_en, 0);
    chk("rst_l_busy", l_busy, 0);
    chk("rst_l_data", l_wr_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed: basic table
    run_small("t1", 16'h1234, 16'hFFF1, 0);
    chk("t1_a0",  s_data[s_w0+0],  16'h0000);
    chk("t1_a1",  s_data[s_w0+1],  16'h1234);
    chk("t1_a15", s_data[s_w0+15], 16'h111B);

    // directed: addition carries out of WIDTH bits
    run_small("t2", 16'hFFFE, 16'hFFFF, 0);
    chk("t2_a1",  s_data[s_w0+1],  16'hFFFE);
    chk("t2_a2",  s_data[s_w0+2],  16'hFFFD);
    chk("t2_a31", s_data[s_w0+31], 16'hFFE0);

    // start held / re-pulsed while busy
    run_small("t3h", 16'h0777, 16'hF00D, 1);
    run_small("t3p", 16'h2345, 16'hABCD, 2);

    // reset in the middle of a build
    w0 = s_addr.size();
    @(negedge clk);
    s_base = 16'h4321; s_mod = 16'hFFF1; s_start = 1'b1; s_st = cyc;
    @(negedge clk);
    s_start = 1'b0;
    for (int t = 0; t < 100 && (cyc - s_st) < 40; t++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_wr_en", s_wr_en, 0);
    chk("t4_busy", s_busy, 0);
    chk("t4_done", s_done, 0);
    chk("t4_n_wr_before", s_addr.size() - w0, 8);
    repeat (5) @(negedge clk);
    chk("t4_n_wr_in_rst", s_addr.size() - w0, 8);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_small("t4r", 16'h4321, 16'hFFF1, 0);

    // B = 0
    run_small("t6", 16'h0000, 16'hBEEF, 0);

    // random short builds
    for (int r = 0; r < 4; r++) begin
      sm = 16'($urandom_range(2, 65535));
      sb = 16'($urandom % 32'(sm));
      run_small($sformatf("rs%0d", r), sb, sm, r % 3);
    end

    // random wide builds
    for (int r = 0; r < 20; r++) begin
      for (int w = 0; w < 32; w++) begin
        lm[w*32 +: 32] = $urandom;
        lb[w*32 +: 32] = $urandom;
      end
      lm[1023] = 1'b1;
      lm[0]    = 1'b1;
      lb = lb % lm;
      run_large($sformatf("rl%0d", r), lb, lm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
